// File: rtl/mmio_periph_bank_if.sv
// Load/store bus between the pipeline MEM stage (master) and the peripheral bank (slave).
interface mmio_periph_bank_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byte_en;
  logic [31:0] rdata;

  modport master (output mem_read, mem_write, addr, wdata, byte_en, input rdata);
  modport slave  (input mem_read, mem_write, addr, wdata, byte_en, output rdata);
endinterface

// File: rtl/mmio_periph_bank.sv
// MEM-stage load/store slave: byte-enable word RAM, prescaled reload timers,
// LED/switch/7-seg GPIO and a UART front-end with RX FIFO; one registered irq.
module mmio_periph_bank #(
  parameter int RAM_WORDS = 256,
  parameter int TIMER_CH  = 2,
  parameter int RX_DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  mmio_periph_bank_if.slave bus,
  input  logic [7:0]        switch,
  output logic [7:0]        led,
  output logic [11:0]       digi,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  output logic              irq
);
  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int RX_AW  = $clog2(RX_DEPTH);
  localparam int CNT_W  = RX_AW + 1;
  localparam logic [CNT_W-1:0] RX_FULL = CNT_W'(RX_DEPTH);

  logic       rd, wr;
  logic       ram_hit, per_base, tmr_blk, gpio_blk, uart_blk;
  logic [1:0] reg_sel;
  logic       unused_addr;

  assign rd          = bus.mem_read;
  assign wr          = bus.mem_write;
  assign reg_sel     = bus.addr[3:2];
  assign ram_hit     = !bus.addr[30] && ({2'b00, bus.addr[31:2]} < 32'(RAM_WORDS));
  assign per_base    = bus.addr[31:12] == 20'h40000;
  assign tmr_blk     = per_base && (bus.addr[11:6] == 6'h00);
  assign gpio_blk    = per_base && (bus.addr[11:4] == 8'h10);
  assign uart_blk    = per_base && (bus.addr[11:4] == 8'h20);
  assign unused_addr = &{1'b0, bus.addr[1:0]};

  logic [TIMER_CH-1:0]       tmr_irq;
  logic [TIMER_CH-1:0][31:0] tmr_rd;

  for (genvar n = 0; n < TIMER_CH; n++) begin : g_tmr
    logic [31:0] th, tl, rv;
    logic [15:0] tpre, pcnt;
    logic        en, ie, st;
    logic        sel, we, tick, ovf;

    assign sel  = tmr_blk && (bus.addr[5:4] == 2'(n));
    assign we   = wr && sel;
    assign tick = en && (pcnt == tpre);
    assign ovf  = tick && (tl == 32'hFFFF_FFFF);

    // A CPU write to TL beats a same-cycle tick; a same-cycle overflow beats the W1C.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        th   <= '0;
        tl   <= '0;
        tpre <= '0;
        pcnt <= '0;
        en   <= 1'b0;
        ie   <= 1'b0;
        st   <= 1'b0;
      end else begin
        if (we && reg_sel == 2'd0) th <= bus.wdata;
        if (we && reg_sel == 2'd1) tl <= bus.wdata;
        else if (tick) tl <= ovf ? th : tl + 32'd1;
        if (we && reg_sel == 2'd3) tpre <= bus.wdata[15:0];
        if ((we && reg_sel == 2'd3) || (we && reg_sel == 2'd2 && bus.wdata[0] && !en))
          pcnt <= '0;
        else if (tick) pcnt <= '0;
        else if (en) pcnt <= pcnt + 16'd1;
        if (we && reg_sel == 2'd2) begin
          en <= bus.wdata[0];
          ie <= bus.wdata[1];
        end
        if (ovf) st <= 1'b1;
        else if (we && reg_sel == 2'd2 && bus.wdata[2]) st <= 1'b0;
      end
    end

    always_comb begin
      rv = 32'd0;
      case (reg_sel)
        2'd0:    rv = th;
        2'd1:    rv = tl;
        2'd2:    rv = {29'd0, st, ie, en};
        default: rv = {16'd0, tpre};
      endcase
    end

    assign tmr_rd[n]  = sel ? rv : 32'd0;
    assign tmr_irq[n] = st & ie;
  end

  logic [31:0] tmr_rdata;
  always_comb begin
    tmr_rdata = 32'd0;
    for (int n = 0; n < TIMER_CH; n++) tmr_rdata = tmr_rdata | tmr_rd[n];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led  <= '0;
      digi <= '0;
    end else begin
      if (wr && gpio_blk && reg_sel == 2'd0) led  <= bus.wdata[7:0];
      if (wr && gpio_blk && reg_sel == 2'd2) digi <= bus.wdata[11:0];
    end
  end

  logic             tx_busy, tx_done_st, rx_ovf, rx_ie;
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wptr, rx_rptr;
  logic [CNT_W-1:0] rx_cnt;
  logic             rx_empty, rx_full, rx_pop, rx_push, rx_drop;
  logic             txd_we, ucon_we, rxd_rd, ucon_rd;

  assign txd_we   = wr && uart_blk && (reg_sel == 2'd0);
  assign ucon_we  = wr && uart_blk && (reg_sel == 2'd2);
  assign rxd_rd   = rd && uart_blk && (reg_sel == 2'd1);
  assign ucon_rd  = rd && uart_blk && (reg_sel == 2'd2);
  assign rx_empty = rx_cnt == '0;
  assign rx_full  = rx_cnt == RX_FULL;
  assign rx_pop   = rxd_rd && !rx_empty;
  assign rx_push  = rx_valid && (!rx_full || rx_pop);
  assign rx_drop  = rx_valid && rx_full && !rx_pop;

  // Set events (tx_done, dropped byte) win over the clear-on-read of UCON.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_data    <= '0;
      tx_start   <= 1'b0;
      tx_busy    <= 1'b0;
      tx_done_st <= 1'b0;
      rx_ovf     <= 1'b0;
      rx_ie      <= 1'b0;
      rx_wptr    <= '0;
      rx_rptr    <= '0;
      rx_cnt     <= '0;
    end else begin
      tx_start <= 1'b0;
      if (tx_done) tx_busy <= 1'b0;
      if (txd_we && !tx_busy) begin
        tx_data  <= bus.wdata[7:0];
        tx_start <= 1'b1;
        tx_busy  <= 1'b1;
      end
      if (tx_done) tx_done_st <= 1'b1;
      else if (ucon_rd) tx_done_st <= 1'b0;
      if (rx_drop) rx_ovf <= 1'b1;
      else if (ucon_rd) rx_ovf <= 1'b0;
      if (ucon_we) rx_ie <= bus.wdata[4];
      if (rx_push) rx_wptr <= rx_wptr + RX_AW'(1);
      if (rx_pop) rx_rptr <= rx_rptr + RX_AW'(1);
      rx_cnt <= rx_cnt + CNT_W'(rx_push) - CNT_W'(rx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr] <= rx_data;
  end

  logic [31:0]       ram [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx;
  assign ram_idx = bus.addr[RAM_AW+1:2];

  always_ff @(posedge clk) begin
    if (wr && ram_hit)
      for (int k = 0; k < 4; k++)
        if (bus.byte_en[k]) ram[ram_idx][8*k +: 8] <= bus.wdata[8*k +: 8];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irq <= 1'b0;
    else      irq <= (|tmr_irq) | (rx_ie & !rx_empty);
  end

  logic [31:0] ucon, rd_mux;
  assign ucon = {16'd0, {(8-CNT_W){1'b0}}, rx_cnt, 3'd0,
                 rx_ie, tx_busy, rx_ovf, !rx_empty, tx_done_st};

  always_comb begin
    rd_mux = 32'd0;
    if (ram_hit) rd_mux = ram[ram_idx];
    else if (tmr_blk) rd_mux = tmr_rdata;
    else if (gpio_blk) begin
      case (reg_sel)
        2'd0:    rd_mux = {24'd0, led};
        2'd1:    rd_mux = {24'd0, switch};
        2'd2:    rd_mux = {20'd0, digi};
        default: rd_mux = 32'd0;
      endcase
    end else if (uart_blk) begin
      case (reg_sel)
        2'd0:    rd_mux = {24'd0, tx_data};
        2'd1:    rd_mux = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rptr]};
        2'd2:    rd_mux = ucon;
        default: rd_mux = 32'd0;
      endcase
    end
  end

  assign bus.rdata = rd ? rd_mux : 32'd0;
endmodule
